// File: rtl/axis_pkt_arb.sv
// axis_pkt_arb: 2:1 packet-level round-robin AXI-Stream arbiter with per-source packet counters
module axis_pkt_arb #(
  parameter int DATA_W = 32,
  parameter int STRB_W = 4,
  parameter int DEST_W = 1,
  parameter int CNT_W  = 16
) (
  input  logic              aclk_0,
  input  logic              aresetn_0,
  input  logic [DATA_W-1:0] S_AXIS_0_tdata,
  input  logic [STRB_W-1:0] S_AXIS_0_tstrb,
  input  logic [DEST_W-1:0] S_AXIS_0_tdest,
  input  logic              S_AXIS_0_tid,
  input  logic              S_AXIS_0_tlast,
  input  logic              S_AXIS_0_tvalid,
  output logic              S_AXIS_0_tready,
  input  logic [DATA_W-1:0] S_AXIS_1_tdata,
  input  logic [STRB_W-1:0] S_AXIS_1_tstrb,
  input  logic [DEST_W-1:0] S_AXIS_1_tdest,
  input  logic              S_AXIS_1_tid,
  input  logic              S_AXIS_1_tlast,
  input  logic              S_AXIS_1_tvalid,
  output logic              S_AXIS_1_tready,
  output logic [DATA_W-1:0] M_AXIS_0_tdata,
  output logic [STRB_W-1:0] M_AXIS_0_tstrb,
  output logic [DEST_W-1:0] M_AXIS_0_tdest,
  output logic              M_AXIS_0_tid,
  output logic              M_AXIS_0_tlast,
  output logic              M_AXIS_0_tvalid,
  input  logic              M_AXIS_0_tready,
  output logic [CNT_W-1:0]  pkt_cnt_0,
  output logic [CNT_W-1:0]  pkt_cnt_1,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             g0, g1, end0, end1;
  logic             unused_tid;
  assign unused_tid = S_AXIS_0_tid ^ S_AXIS_1_tid;
  assign g0   = state_q == GNT0;
  assign g1   = state_q == GNT1;
  assign end0 = g0 & S_AXIS_0_tvalid & M_AXIS_0_tready & S_AXIS_0_tlast;
  assign end1 = g1 & S_AXIS_1_tvalid & M_AXIS_0_tready & S_AXIS_1_tlast;
  assign busy = state_q != IDLE;
  assign pkt_cnt_0 = cnt0_q;
  assign pkt_cnt_1 = cnt1_q;
  // Zero-latency datapath mux; readies follow only the grant and downstream ready
  always_comb begin
    M_AXIS_0_tdata  = g1 ? S_AXIS_1_tdata : S_AXIS_0_tdata;
    M_AXIS_0_tstrb  = g1 ? S_AXIS_1_tstrb : S_AXIS_0_tstrb;
    M_AXIS_0_tdest  = g1 ? S_AXIS_1_tdest : S_AXIS_0_tdest;
    M_AXIS_0_tlast  = g1 ? S_AXIS_1_tlast : S_AXIS_0_tlast;
    M_AXIS_0_tvalid = g0 ? S_AXIS_0_tvalid : g1 ? S_AXIS_1_tvalid : 1'b0;
    M_AXIS_0_tid    = g1;
    S_AXIS_0_tready = g0 & M_AXIS_0_tready;
    S_AXIS_1_tready = g1 & M_AXIS_0_tready;
  end
  // Grant decision in IDLE, packet lock until tlast, then hand over or fall back to IDLE
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    unique case (state_q)
      IDLE: state_d = (S_AXIS_0_tvalid & S_AXIS_1_tvalid) ? (last_q ? GNT0 : GNT1) :
                      S_AXIS_0_tvalid ? GNT0 : S_AXIS_1_tvalid ? GNT1 : IDLE;
      GNT0: if (end0) begin
        last_d  = 1'b0;
        cnt0_d  = cnt0_q + 1'b1;
        state_d = S_AXIS_1_tvalid ? GNT1 : IDLE;
      end
      GNT1: if (end1) begin
        last_d  = 1'b1;
        cnt1_d  = cnt1_q + 1'b1;
        state_d = S_AXIS_0_tvalid ? GNT0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State, round-robin pointer and counters; reset makes port 0 win first
  always_ff @(posedge aclk_0 or negedge aresetn_0) begin
    if (!aresetn_0) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end
endmodule

// File: tb/tb_axis_pkt_arb.sv
// tb_axis_pkt_arb: randomized scoreboard bench for the packet arbiter
module tb_axis_pkt_arb;
  typedef struct packed {logic [31:0] d; logic [3:0] s; logic de; logic l;} beat_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sv [2];
  logic [31:0] sd [2];
  logic [3:0]  ss [2];
  logic        sde [2], sl [2], stid [2];
  logic        rdy0, rdy1, m_valid, m_rdy, m_last, m_tid, m_dest, busy;
  logic [31:0] m_data;
  logic [3:0]  m_strb;
  logic [15:0] cnt0, cnt1;
  beat_t       sq [2][$];
  beat_t       exq [2][$];
  int          order [$];
  int          total = 0, bad = 0, cyc = 0;
  int          mcnt [2];
  int          first_sv = -1, first_beat = -1, last_beat = -1, nbeats = 0;
  bit          in_pkt = 0;
  int          cur = 0;

  always #5 clk = ~clk;

  axis_pkt_arb dut (
    .aclk_0(clk), .aresetn_0(rst_n),
    .S_AXIS_0_tdata(sd[0]), .S_AXIS_0_tstrb(ss[0]), .S_AXIS_0_tdest(sde[0]), .S_AXIS_0_tid(stid[0]),
    .S_AXIS_0_tlast(sl[0]), .S_AXIS_0_tvalid(sv[0]), .S_AXIS_0_tready(rdy0),
    .S_AXIS_1_tdata(sd[1]), .S_AXIS_1_tstrb(ss[1]), .S_AXIS_1_tdest(sde[1]), .S_AXIS_1_tid(stid[1]),
    .S_AXIS_1_tlast(sl[1]), .S_AXIS_1_tvalid(sv[1]), .S_AXIS_1_tready(rdy1),
    .M_AXIS_0_tdata(m_data), .M_AXIS_0_tstrb(m_strb), .M_AXIS_0_tdest(m_dest), .M_AXIS_0_tid(m_tid),
    .M_AXIS_0_tlast(m_last), .M_AXIS_0_tvalid(m_valid), .M_AXIS_0_tready(m_rdy),
    .pkt_cnt_0(cnt0), .pkt_cnt_1(cnt1), .busy(busy)
  );

  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  task automatic add_pkt(input int p, input int len, input logic [31:0] base);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.d = base + i;
      b.s = 4'($urandom_range(15));
      b.de = 1'($urandom_range(1));
      b.l = (i == len - 1);
      sq[p].push_back(b);
      exq[p].push_back(b);
    end
  endtask

  task automatic clear_stats();
    order.delete();
    first_sv = -1;
    first_beat = -1;
    last_beat = -1;
    nbeats = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      sv[p] = 1'b0;
      sq[p].delete();
      exq[p].delete();
      mcnt[p] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_stats();
  endtask

  task automatic run(input int rdy_pct, input int gap_pct, input int hold0, input int abort_at, input int max_cyc);
    int  c = 0, acc = 0;
    logic hs [2];
    forever begin
      @(negedge clk);
      hs[0] = sv[0] & rdy0;
      hs[1] = sv[1] & rdy1;
      @(posedge clk);
      #1;
      cyc++;
      c++;
      for (int p = 0; p < 2; p++) begin
        if (hs[p]) begin
          void'(sq[p].pop_front());
          acc++;
        end
        if (!(sv[p] && !hs[p]))
          sv[p] = sq[p].size() > 0 && (p != 0 || c > hold0) && $urandom_range(99) >= gap_pct;
        if (sq[p].size() > 0) {sd[p], ss[p], sde[p], sl[p]} = sq[p][0];
        stid[p] = 1'($urandom_range(1));
      end
      m_rdy = $urandom_range(99) < rdy_pct;
      if (first_sv < 0 && (sv[0] || sv[1])) first_sv = cyc;
      if (abort_at > 0 && acc == abort_at && sv[0]) begin
        rst_n = 1'b0;
        return;
      end
      if (sq[0].size() == 0 && sq[1].size() == 0) return;
      if (c >= max_cyc) begin
        total++;
        bad++;
        $display("FAIL run_timeout: %0d cycles elapsed, %0d/%0d beats left", c, sq[0].size(), sq[1].size());
        return;
      end
    end
  endtask

  initial begin
    int p;
    beat_t got, e;
    forever begin
      @(negedge clk);
      if (!rst_n) in_pkt = 0;
      else begin
        if (in_pkt) begin
          chk("rdy_granted", cur != 0 ? rdy1 : rdy0, m_rdy);
          chk("rdy_other", cur != 0 ? rdy0 : rdy1, 0);
        end
        if (m_valid && m_rdy) begin
          p = int'(m_tid);
          got = {m_data, m_strb, m_dest, m_last};
          if (in_pkt) chk("interleave", p, cur);
          if (exq[p].size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected: tid=%0d data=%h with nothing pending", p, m_data);
          end else begin
            e = exq[p].pop_front();
            chk("beat", got, e);
          end
          if (first_beat < 0) first_beat = cyc;
          last_beat = cyc;
          nbeats++;
          if (m_last) begin
            order.push_back(p);
            mcnt[p]++;
            in_pkt = 0;
          end else begin
            in_pkt = 1;
            cur = p;
          end
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      sv[p] = 1'b1; sd[p] = '0; ss[p] = '0; sde[p] = 1'b0; sl[p] = 1'b0; stid[p] = 1'b0; mcnt[p] = 0;
    end
    m_rdy = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mvalid", m_valid, 0);
    chk("rst_rdy0", rdy0, 0);
    chk("rst_rdy1", rdy1, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_busy", busy, 0);
    sv[0] = 1'b0;
    sv[1] = 1'b0;
    rst_n = 1'b1;

    clear_stats();
    add_pkt(0, 4, 32'h11);
    run(100, 0, 0, 0, 200);
    chk("p2_latency", first_beat - first_sv, 1);
    chk("p2_order", order.size() == 1 ? order[0] : -1, 0);
    chk("p2_cnt0", cnt0, 1);
    chk("p2_cnt1", cnt1, 0);
    chk("p2_idle", busy, 0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      add_pkt(0, 3, $urandom);
      add_pkt(1, 3, $urandom);
    end
    run(100, 0, 0, 0, 500);
    chk("p3_npkts", order.size(), 10);
    foreach (order[i]) chk("p3_alternate", order[i], i % 2);
    chk("p3_no_bubble", last_beat - first_beat + 1, 30);
    chk("p3_cnt0", cnt0, 5);
    chk("p3_cnt1", cnt1, 5);

    clear_stats();
    add_pkt(1, 6, $urandom);
    add_pkt(0, 3, $urandom);
    run(100, 0, 3, 0, 500);
    chk("p4_first", order.size() == 2 ? order[0] : -1, 1);
    chk("p4_second", order.size() == 2 ? order[1] : -1, 0);
    chk("p4_cnt0", cnt0, mcnt[0]);
    chk("p4_cnt1", cnt1, mcnt[1]);

    do_reset();
    for (int i = 0; i < 1000; i++) add_pkt($urandom_range(1), $urandom_range(1, 4), $urandom);
    run(50, 30, 0, 0, 40000);
    chk("p5_left0", exq[0].size(), 0);
    chk("p5_left1", exq[1].size(), 0);
    chk("p5_cnt0", cnt0, mcnt[0]);
    chk("p5_cnt1", cnt1, mcnt[1]);
    chk("p5_sum", cnt0 + cnt1, 1000);

    do_reset();
    add_pkt(0, 5, $urandom);
    run(100, 0, 0, 1, 100);
    #1;
    chk("p6_mvalid", m_valid, 0);
    chk("p6_rdy0", rdy0, 0);
    chk("p6_busy", busy, 0);
    chk("p6_cnt0", cnt0, 0);
    for (int p = 0; p < 2; p++) begin
      sv[p] = 1'b0;
      sq[p].delete();
      exq[p].delete();
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_stats();
    add_pkt(1, 2, $urandom);
    add_pkt(0, 2, $urandom);
    run(100, 0, 0, 0, 100);
    chk("p6_first_port0", order.size() == 2 ? order[0] : -1, 0);
    chk("p6_cnt0", cnt0, 1);
    chk("p6_cnt1", cnt1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
